// File: rtl/ampfind_hyst.sv
// Hysteresis-qualified peak/trough tracker for a sampled waveform.
// Reports max, min, amplitude, mean and period once per completed cycle, and flags DC input.
module ampfind_hyst #(
   parameter int DATA_W   = 12,
   parameter int HYST     = 4,
   parameter int PERIOD_W = 20,
   parameter int TIMEOUT  = 100000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sample_en,
   input  logic [DATA_W-1:0]   data_in,
   output logic [DATA_W-1:0]   max_val,
   output logic [DATA_W-1:0]   min_val,
   output logic [DATA_W-1:0]   amp,
   output logic [DATA_W-1:0]   mean,
   output logic [PERIOD_W-1:0] period,
   output logic                meas_valid,
   output logic                dc_flag
);

   typedef enum logic [1:0] {IDLE = 2'd0, RISE = 2'd1, FALL = 2'd2} state_t;

   localparam logic [DATA_W:0]     HYST_X   = (DATA_W+1)'(HYST);
   localparam logic [PERIOD_W-1:0] TMO_LAST = PERIOD_W'(TIMEOUT - 1);

   state_t              state_reg;
   logic                first_reg;
   logic                have_trough_reg;
   logic [DATA_W-1:0]   run_max_reg;
   logic [DATA_W-1:0]   run_min_reg;
   logic [DATA_W-1:0]   pk_reg;
   logic [PERIOD_W-1:0] idx_reg;
   logic [PERIOD_W-1:0] trough_idx_reg;
   logic [PERIOD_W-1:0] prev_trough_idx_reg;
   logic [PERIOD_W-1:0] tmo_cnt_reg;

   logic [DATA_W-1:0] cur_max;
   logic [DATA_W-1:0] cur_min;
   logic [DATA_W-1:0] amp_calc;
   logic [DATA_W-1:0] mean_calc;
   logic [DATA_W:0]   d_x;
   logic [DATA_W:0]   max_x;
   logic [DATA_W:0]   min_x;
   logic              rise_hit;
   logic              fall_hit;
   logic              peak_conf;
   logic              trough_conf;
   logic              timeout;

   always_comb begin
      // The very first sample after reset seeds both running extremes.
      cur_max     = first_reg ? data_in : run_max_reg;
      cur_min     = first_reg ? data_in : run_min_reg;
      d_x         = {1'b0, data_in};
      max_x       = {1'b0, cur_max};
      min_x       = {1'b0, cur_min};
      rise_hit    = d_x >= (min_x + HYST_X);
      fall_hit    = (d_x + HYST_X) <= max_x;
      peak_conf   = (state_reg == RISE) && fall_hit;
      trough_conf = (state_reg == FALL) && rise_hit;
      timeout     = !peak_conf && !trough_conf && (tmo_cnt_reg == TMO_LAST);
      amp_calc    = (pk_reg - run_min_reg) >> 1;
      mean_calc   = DATA_W'(({1'b0, pk_reg} + {1'b0, run_min_reg}) >> 1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg           <= IDLE;
         first_reg           <= 1'b1;
         have_trough_reg     <= 1'b0;
         run_max_reg         <= '0;
         run_min_reg         <= '0;
         pk_reg              <= '0;
         idx_reg             <= '0;
         trough_idx_reg      <= '0;
         prev_trough_idx_reg <= '0;
         tmo_cnt_reg         <= '0;
         max_val             <= '0;
         min_val             <= '1;
         amp                 <= '0;
         mean                <= '0;
         period              <= '0;
         meas_valid          <= 1'b0;
         dc_flag             <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         if (sample_en) begin
            first_reg <= 1'b0;
            idx_reg   <= idx_reg + 1'b1;
            if (timeout) begin
               state_reg       <= IDLE;
               have_trough_reg <= 1'b0;
               tmo_cnt_reg     <= '0;
               run_max_reg     <= data_in;
               run_min_reg     <= data_in;
               max_val         <= data_in;
               min_val         <= data_in;
               mean            <= data_in;
               amp             <= '0;
               period          <= '0;
               dc_flag         <= 1'b1;
            end else begin
               tmo_cnt_reg <= (peak_conf || trough_conf) ? '0 : tmo_cnt_reg + 1'b1;
               case (state_reg)
                  IDLE: begin
                     run_max_reg <= (data_in > cur_max) ? data_in : cur_max;
                     run_min_reg <= (data_in < cur_min) ? data_in : cur_min;
                     if (rise_hit) begin
                        state_reg   <= RISE;
                        run_max_reg <= data_in;
                     end else if (fall_hit) begin
                        state_reg      <= FALL;
                        run_min_reg    <= data_in;
                        trough_idx_reg <= idx_reg;
                     end
                  end
                  RISE: begin
                     if (data_in > run_max_reg) run_max_reg <= data_in;
                     if (peak_conf) begin
                        pk_reg         <= run_max_reg;
                        state_reg      <= FALL;
                        run_min_reg    <= data_in;
                        trough_idx_reg <= idx_reg;
                     end
                  end
                  FALL: begin
                     // Strict compare keeps the earliest index of a flat-bottomed trough.
                     if (data_in < run_min_reg) begin
                        run_min_reg    <= data_in;
                        trough_idx_reg <= idx_reg;
                     end
                     if (trough_conf) begin
                        state_reg           <= RISE;
                        run_max_reg         <= data_in;
                        prev_trough_idx_reg <= trough_idx_reg;
                        have_trough_reg     <= 1'b1;
                        if (have_trough_reg) begin
                           max_val    <= pk_reg;
                           min_val    <= run_min_reg;
                           amp        <= amp_calc;
                           mean       <= mean_calc;
                           period     <= trough_idx_reg - prev_trough_idx_reg;
                           meas_valid <= 1'b1;
                           dc_flag    <= 1'b0;
                        end
                     end
                  end
                  default: state_reg <= IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_ampfind_hyst.sv
// Randomised and directed bench for ampfind_hyst, checked cycle by cycle against
// an integer reference model of the peak/trough/timeout rules.
module tb_ampfind_hyst;
   localparam int DATA_W   = 12;
   localparam int HYST     = 4;
   localparam int PERIOD_W = 20;
   localparam int TIMEOUT  = 64;
   localparam int P_MASK   = (1 << PERIOD_W) - 1;

   logic                clk = 1'b0;
   logic                rst;
   logic                sample_en;
   logic [DATA_W-1:0]   data_in;
   logic [DATA_W-1:0]   max_val;
   logic [DATA_W-1:0]   min_val;
   logic [DATA_W-1:0]   amp;
   logic [DATA_W-1:0]   mean;
   logic [PERIOD_W-1:0] period;
   logic                meas_valid;
   logic                dc_flag;

   ampfind_hyst #(
      .DATA_W(DATA_W), .HYST(HYST), .PERIOD_W(PERIOD_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .sample_en(sample_en), .data_in(data_in),
      .max_val(max_val), .min_val(min_val), .amp(amp), .mean(mean),
      .period(period), .meas_valid(meas_valid), .dc_flag(dc_flag)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Reference model: mode 0 = hunting, 1 = climbing toward a peak, 2 = descending toward a trough
   int m_mode, m_first, m_rmax, m_rmin, m_pk, m_tidx, m_ptidx, m_have, m_idx, m_tmo;
   int e_max, e_min, e_amp, e_mean, e_period, e_mv, e_dc;

   task automatic model_reset();
      m_mode = 0; m_first = 1; m_rmax = 0; m_rmin = 0; m_pk = 0;
      m_tidx = 0; m_ptidx = 0; m_have = 0; m_idx = 0; m_tmo = 0;
      e_max = 0; e_min = (1 << DATA_W) - 1; e_amp = 0; e_mean = 0;
      e_period = 0; e_mv = 0; e_dc = 0;
   endtask

   task automatic model_step(input int d);
      bit confirmed;
      confirmed = 0;
      if (m_first != 0) begin
         m_rmax = d; m_rmin = d; m_first = 0;
      end
      if (m_mode == 0) begin
         if (d >= m_rmin + HYST) begin
            m_mode = 1; m_rmax = d;
         end else if (d + HYST <= m_rmax) begin
            m_mode = 2; m_rmin = d; m_tidx = m_idx;
         end else begin
            if (d > m_rmax) m_rmax = d;
            if (d < m_rmin) m_rmin = d;
         end
      end else if (m_mode == 1) begin
         if (d > m_rmax) m_rmax = d;
         else if (d + HYST <= m_rmax) begin
            confirmed = 1; m_pk = m_rmax; m_mode = 2; m_rmin = d; m_tidx = m_idx;
         end
      end else begin
         if (d < m_rmin) begin
            m_rmin = d; m_tidx = m_idx;
         end else if (d >= m_rmin + HYST) begin
            confirmed = 1;
            if (m_have != 0) begin
               e_max = m_pk; e_min = m_rmin;
               e_amp = (m_pk - m_rmin) / 2;
               e_mean = (m_pk + m_rmin) / 2;
               e_period = (m_tidx - m_ptidx) & P_MASK;
               e_mv = 1; e_dc = 0;
            end
            m_ptidx = m_tidx; m_have = 1; m_mode = 1; m_rmax = d;
         end
      end
      if (confirmed) m_tmo = 0;
      else if (m_tmo + 1 == TIMEOUT) begin
         m_tmo = 0; m_mode = 0; m_have = 0; m_rmax = d; m_rmin = d;
         e_max = d; e_min = d; e_mean = d; e_amp = 0; e_period = 0; e_dc = 1;
      end else m_tmo = m_tmo + 1;
      m_idx = (m_idx + 1) & P_MASK;
   endtask

   int cyc = 0;
   int mv_count = 0;
   int last_mv_cyc = 0;
   int prev_mv_cyc = 0;
   int cap_max, cap_min, cap_amp, cap_mean, cap_period;

   task automatic apply(input logic r, input logic en, input int d);
      rst = r; sample_en = en; data_in = d[DATA_W-1:0];
      @(posedge clk);
      #1;
      cyc++;
      e_mv = 0;
      if (r) model_reset();
      else if (en) model_step(d);
      check("max_val", max_val, e_max);
      check("min_val", min_val, e_min);
      check("amp", amp, e_amp);
      check("mean", mean, e_mean);
      check("period", period, e_period);
      check("meas_valid", meas_valid, e_mv);
      check("dc_flag", dc_flag, e_dc);
      if (meas_valid) begin
         mv_count++;
         prev_mv_cyc = last_mv_cyc; last_mv_cyc = cyc;
         cap_max = max_val; cap_min = min_val; cap_amp = amp;
         cap_mean = mean; cap_period = period;
      end
   endtask

   function automatic int tri_wave(input int lo, input int hi, input int step, input int k);
      int n, p;
      n = (hi - lo) / step;
      p = k % (2 * n);
      return (p <= n) ? lo + p * step : hi - (p - n) * step;
   endfunction

   task automatic do_reset();
      apply(1'b1, 1'b1, 0);
      mv_count = 0;
   endtask

   task automatic check_caps(input string tag, input int mx, input int mn, input int a,
                             input int mu, input int per);
      check({tag, "_max"}, cap_max, mx);
      check({tag, "_min"}, cap_min, mn);
      check({tag, "_amp"}, cap_amp, a);
      check({tag, "_mean"}, cap_mean, mu);
      check({tag, "_period"}, cap_period, per);
   endtask

   initial begin
      int fs[12];
      int first_mv;
      int walk;
      model_reset();
      rst = 1'b1; sample_en = 1'b0; data_in = '0;

      // Reset state
      apply(1'b1, 1'b0, 0);
      do_reset();
      check("rst_max", max_val, 0);
      check("rst_min", min_val, 4095);
      check("rst_mv", meas_valid, 0);
      check("rst_dc", dc_flag, 0);

      // Plain triangle, 40-sample period
      for (int k = 0; k < 200; k++) apply(1'b0, 1'b1, tri_wave(1000, 3000, 100, k));
      check("tri_count", mv_count, 3);
      check("tri_spacing", last_mv_cyc - prev_mv_cyc, 40);
      check_caps("tri", 3000, 1000, 1000, 2000, 40);

      // Same triangle with sample_en alternating; garbage data on idle clocks
      do_reset();
      for (int k = 0; k < 200; k++) begin
         apply(1'b0, 1'b1, tri_wave(1000, 3000, 100, k));
         apply(1'b0, 1'b0, int'($urandom_range(0, 4095)));
      end
      check("en_count", mv_count, 3);
      check("en_spacing", last_mv_cyc - prev_mv_cyc, 80);
      check_caps("en", 3000, 1000, 1000, 2000, 40);

      // DC timeout, then recovery on the triangle
      do_reset();
      for (int k = 0; k < TIMEOUT - 1; k++) apply(1'b0, 1'b1, 2048);
      check("dc_early", dc_flag, 0);
      apply(1'b0, 1'b1, 2048);
      check("dc_flag", dc_flag, 1);
      check("dc_max", max_val, 2048);
      check("dc_min", min_val, 2048);
      check("dc_mean", mean, 2048);
      check("dc_amp", amp, 0);
      check("dc_period", period, 0);
      check("dc_no_mv", mv_count, 0);
      for (int k = 0; k < 200; k++) apply(1'b0, 1'b1, tri_wave(1000, 3000, 100, k));
      check("dc_clear", dc_flag, 0);
      check("dc_rec_count", mv_count, 4);
      check_caps("dc_rec", 3000, 1000, 1000, 2000, 40);

      // Full-scale square-ish ramp
      fs = '{0, 0, 0, 1024, 2048, 3072, 4095, 4095, 4095, 3072, 2048, 1024};
      do_reset();
      for (int k = 0; k < 60; k++) apply(1'b0, 1'b1, fs[k % 12]);
      check("fs_count", mv_count, 3);
      check_caps("fs", 4095, 0, 2047, 2047, 12);

      // Sub-hysteresis ripple riding on a slow ramp
      do_reset();
      for (int k = 0; k < 400; k++) begin
         int r;
         case (k % 4)
            1: r = 2;
            3: r = -2;
            default: r = 0;
         endcase
         apply(1'b0, 1'b1, tri_wave(1000, 1500, 10, k) + r);
      end
      check("rip_count", mv_count, 2);
      check_caps("rip", 1500, 1000, 250, 1250, 100);

      // Reset while descending, then two fresh troughs are needed
      do_reset();
      for (int k = 0; k < 150; k++) apply(1'b0, 1'b1, tri_wave(1000, 3000, 100, k));
      check("mid_count", mv_count, 2);
      apply(1'b1, 1'b1, tri_wave(1000, 3000, 100, 150));
      check("mid_rst_max", max_val, 0);
      check("mid_rst_min", min_val, 4095);
      check("mid_rst_period", period, 0);
      mv_count = 0;
      first_mv = 0;
      for (int n = 1; n <= 60; n++) begin
         apply(1'b0, 1'b1, tri_wave(1000, 3000, 100, 30 + n));
         if (meas_valid && first_mv == 0) first_mv = n;
      end
      check("mid_first_mv", first_mv, 51);
      check_caps("mid", 3000, 1000, 1000, 2000, 40);

      // Randomised segments: walks, flats (timeouts) and noise, with random sample_en
      do_reset();
      walk = 2048;
      for (int seg = 0; seg < 10; seg++) begin
         int typ;
         typ = int'($urandom_range(0, 2));
         for (int i = 0; i < 100; i++) begin
            logic en;
            en = ($urandom_range(0, 3) != 0);
            if (typ == 0) begin
               walk = walk + int'($urandom_range(0, 60)) - 30;
               if (walk < 0) walk = 0;
               if (walk > 4095) walk = 4095;
            end else if (typ == 2) begin
               walk = int'($urandom_range(0, 4095));
            end
            apply(1'b0, en, walk);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
